// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three requesting masters (debug, LSU, IF), the arbiter and the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the environment (masters plus RAM).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Handshake: a master raises mN_req_i and holds we/addr/wdata/wstrb stable until the
  // one-cycle mN_gnt_o pulse; the transaction ends with a one-cycle mN_rvalid_o pulse
  // carrying rdata/err. Toward the RAM, s_req_o is held until s_ack_i (rdata valid in
  // the same cycle) or until the arbiter gives up on a timeout.
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [STRB_W-1:0] m0_wstrb_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [STRB_W-1:0] m1_wstrb_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_err_o;

  logic              m2_req_i;
  logic              m2_we_i;
  logic [ADDR_W-1:0] m2_addr_i;
  logic [DATA_W-1:0] m2_wdata_i;
  logic [STRB_W-1:0] m2_wstrb_i;
  logic              m2_gnt_o;
  logic              m2_rvalid_o;
  logic [DATA_W-1:0] m2_rdata_o;
  logic              m2_err_o;

  logic              s_req_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic [STRB_W-1:0] s_wstrb_o;
  logic              s_ack_i;
  logic [DATA_W-1:0] s_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wstrb_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i, m2_wstrb_i,
    output m2_gnt_o, m2_rvalid_o, m2_rdata_o, m2_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o,
    input  s_ack_i, s_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wstrb_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i, m2_wstrb_i,
    input  m2_gnt_o, m2_rvalid_o, m2_rdata_o, m2_err_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o,
    output s_ack_i, s_rdata_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Three-master arbiter for the shared RAM port: fixed priority debug > LSU > IF with an IF
// starvation boost, one transaction in flight, slave timeout and flush of IF responses.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int STARVE_MAX  = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             flush_i,
  output logic [1:0]       stall_o,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_age,
  mem_bus_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STARVE  = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q;
  logic [1:0]        owner_q;
  logic [CNT_W-1:0]  tcnt_q;
  logic [CNT_W-1:0]  age_q;
  logic              flushed_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              s_req_q;
  logic              s_we_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [STRB_W-1:0] s_wstrb_q;

  logic [2:0]        req;
  logic [2:0]        gnt;
  logic [2:0]        rvalid;
  logic [1:0]        win;
  logic              resp_kill;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  // A starved IF request outranks both other masters for exactly one arbitration.
  always_comb begin
    req = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    win = 2'd2;
    if (req[2] && (age_q == STARVE)) win = 2'd2;
    else if (req[0])                 win = 2'd0;
    else if (req[1])                 win = 2'd1;
    gnt = ((state_q == IDLE) && (req != 3'b000)) ? (3'b001 << win) : 3'b000;
  end

  always_comb begin
    sel_we    = bus.m0_we_i;
    sel_addr  = bus.m0_addr_i;
    sel_wdata = bus.m0_wdata_i;
    sel_wstrb = bus.m0_wstrb_i;
    case (win)
      2'd1: begin
        sel_we    = bus.m1_we_i;
        sel_addr  = bus.m1_addr_i;
        sel_wdata = bus.m1_wdata_i;
        sel_wstrb = bus.m1_wstrb_i;
      end
      2'd2: begin
        sel_we    = bus.m2_we_i;
        sel_addr  = bus.m2_addr_i;
        sel_wdata = bus.m2_wdata_i;
        sel_wstrb = bus.m2_wstrb_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      tcnt_q    <= '0;
      age_q     <= '0;
      flushed_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else begin
      if (!req[2]) begin
        age_q <= '0;
      end else if (state_q == IDLE) begin
        if (flush_i || gnt[2]) age_q <= '0;
        else if (age_q < STARVE) age_q <= age_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (req != 3'b000) begin
            state_q   <= BUSY;
            owner_q   <= win;
            tcnt_q    <= '0;
            flushed_q <= 1'b0;
            s_req_q   <= 1'b1;
            s_we_q    <= sel_we;
            s_addr_q  <= sel_addr;
            s_wdata_q <= sel_wdata;
            s_wstrb_q <= sel_wstrb;
          end
        end
        BUSY: begin
          if ((owner_q == 2'd2) && flush_i) flushed_q <= 1'b1;
          if (bus.s_ack_i) begin
            rdata_q <= bus.s_rdata_i;
            err_q   <= 1'b0;
            s_req_q <= 1'b0;
            tcnt_q  <= '0;
            state_q <= RESP;
          end else if (tcnt_q == TO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            s_req_q <= 1'b0;
            tcnt_q  <= '0;
            state_q <= RESP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush seen during the response cycle itself still kills the IF completion.
  assign resp_kill = (owner_q == 2'd2) && (flushed_q || flush_i);
  assign rvalid    = ((state_q == RESP) && !resp_kill) ? (3'b001 << owner_q) : 3'b000;

  assign bus.m0_gnt_o    = gnt[0];
  assign bus.m1_gnt_o    = gnt[1];
  assign bus.m2_gnt_o    = gnt[2];
  assign bus.m0_rvalid_o = rvalid[0];
  assign bus.m1_rvalid_o = rvalid[1];
  assign bus.m2_rvalid_o = rvalid[2];
  assign bus.m0_rdata_o  = rdata_q;
  assign bus.m1_rdata_o  = rdata_q;
  assign bus.m2_rdata_o  = rdata_q;
  assign bus.m0_err_o    = err_q;
  assign bus.m1_err_o    = err_q;
  assign bus.m2_err_o    = err_q;

  assign bus.s_req_o   = s_req_q;
  assign bus.s_we_o    = s_we_q;
  assign bus.s_addr_o  = s_addr_q;
  assign bus.s_wdata_o = s_wdata_q;
  assign bus.s_wstrb_o = s_wstrb_q;

  assign stall_o[0] = (req[1] && !gnt[1]) || ((state_q == BUSY) && (owner_q == 2'd1));
  assign stall_o[1] = (req[2] && !gnt[2]) || ((state_q == BUSY) && (owner_q == 2'd2));

  assign dbg_state = state_q;
  assign dbg_age   = age_q;
endmodule
